// File: rtl/arbitro_memoria_dados.sv
// Purpose : two-port round-robin arbiter and access sequencer in front of a
//           single-port data memory (write on rising edge, read on falling edge).
// Latency : 3 cycles per access (OCIOSO -> ACESSO -> RESPOSTA). Pronto pulses in
//           the second cycle after the grant edge. Back-to-back requests are served
//           one every 3 cycles.
// Backpressure: a requester holds Req and its operands stable until its Pronto
//           pulse. A losing port simply keeps waiting in OCIOSO.
//
// Ports:
//   Clock, Reset            rising-edge clock, asynchronous active-high reset
//   Req0/Esc0/End0/Dado0    port 0 (CPU) request, 1=write, address, write data
//   Pronto0/DadoLido0       port 0 completion pulse and read data
//   Req1 .. DadoLido1       same for port 1 (loader / debug)
//   MemEndereco, MemDadoEscrito, MemEscMem, MemLerMem, MemDadoLido
//                           single-port memory interface
//   ContAcessos0/1          (only with ARBITRO_CONTADORES_EN) 16-bit completed
//                           access counters per port, wrapping
//
// Optional build macro: ARBITRO_CONTADORES_EN adds the per-port access counters.
module arbitro_memoria_dados #(
  parameter int LARGURA_END  = 8,
  parameter int LARGURA_DADO = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Req0,
  input  logic                    Esc0,
  input  logic [LARGURA_END-1:0]  End0,
  input  logic [LARGURA_DADO-1:0] Dado0,
  output logic                    Pronto0,
  output logic [LARGURA_DADO-1:0] DadoLido0,
  input  logic                    Req1,
  input  logic                    Esc1,
  input  logic [LARGURA_END-1:0]  End1,
  input  logic [LARGURA_DADO-1:0] Dado1,
  output logic                    Pronto1,
  output logic [LARGURA_DADO-1:0] DadoLido1,
  output logic [LARGURA_END-1:0]  MemEndereco,
  output logic [LARGURA_DADO-1:0] MemDadoEscrito,
  output logic                    MemEscMem,
  output logic                    MemLerMem,
  input  logic [LARGURA_DADO-1:0] MemDadoLido
`ifdef ARBITRO_CONTADORES_EN
  ,
  output logic [15:0]             ContAcessos0,
  output logic [15:0]             ContAcessos1
`endif
);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] ACESSO   = 2'd1;
  localparam logic [1:0] RESPOSTA = 2'd2;

  logic [1:0]              state_q,   state_d;
  logic                    grant_q,   grant_d;   // port owning the current access
  logic                    ultimo_q,  ultimo_d;  // last port served, loses the next tie
  logic [LARGURA_END-1:0]  end_q,     end_d;
  logic [LARGURA_DADO-1:0] dado_q,    dado_d;
  logic                    esc_q,     esc_d;
  logic                    ler_q,     ler_d;
  logic                    pronto0_q, pronto0_d;
  logic                    pronto1_q, pronto1_d;
  logic [LARGURA_DADO-1:0] lido0_q,   lido0_d;
  logic [LARGURA_DADO-1:0] lido1_q,   lido1_d;

  logic                    sel;       // port chosen in OCIOSO this cycle
  logic                    esc_sel;   // access type of the chosen port

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ultimo_d  = ultimo_q;
    end_d     = end_q;
    dado_d    = dado_q;
    esc_d     = esc_q;
    ler_d     = ler_q;
    pronto0_d = 1'b0;
    pronto1_d = 1'b0;
    lido0_d   = lido0_q;
    lido1_d   = lido1_q;
    sel       = 1'b0;
    esc_sel   = 1'b0;

    case (state_q)
      OCIOSO: begin
        esc_d = 1'b0;
        ler_d = 1'b0;
        if (Req0 || Req1) begin
          // A lone request wins outright; on a tie the port that was not
          // served last wins, giving strict alternation under full load.
          sel     = (Req0 && Req1) ? ~ultimo_q : Req1;
          esc_sel = sel ? Esc1 : Esc0;
          grant_d = sel;
          // Operands are latched here so later requester changes cannot
          // disturb the access in flight.
          end_d   = sel ? End1  : End0;
          dado_d  = sel ? Dado1 : Dado0;
          esc_d   = esc_sel;
          ler_d   = ~esc_sel;
          state_d = ACESSO;
        end
      end

      ACESSO: begin
        // Memory already drove read data on the mid-cycle falling edge.
        if (ler_q) begin
          if (grant_q) lido1_d = MemDadoLido;
          else         lido0_d = MemDadoLido;
        end
        esc_d     = 1'b0;
        ler_d     = 1'b0;
        pronto0_d = ~grant_q;
        pronto1_d = grant_q;
        ultimo_d  = grant_q;
        state_d   = RESPOSTA;
      end

      RESPOSTA: begin
        state_d = OCIOSO;
      end

      default: begin
        esc_d   = 1'b0;
        ler_d   = 1'b0;
        state_d = OCIOSO;
      end
    endcase
  end

  // Strobes are plain registers, so the async reset removes them at once and an
  // unfinished write never sees its closing rising edge with MemEscMem high.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= OCIOSO;
      grant_q   <= 1'b0;
      ultimo_q  <= 1'b1;
      end_q     <= '0;
      dado_q    <= '0;
      esc_q     <= 1'b0;
      ler_q     <= 1'b0;
      pronto0_q <= 1'b0;
      pronto1_q <= 1'b0;
      lido0_q   <= '0;
      lido1_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ultimo_q  <= ultimo_d;
      end_q     <= end_d;
      dado_q    <= dado_d;
      esc_q     <= esc_d;
      ler_q     <= ler_d;
      pronto0_q <= pronto0_d;
      pronto1_q <= pronto1_d;
      lido0_q   <= lido0_d;
      lido1_q   <= lido1_d;
    end
  end

  assign MemEndereco    = end_q;
  assign MemDadoEscrito = dado_q;
  assign MemEscMem      = esc_q;
  assign MemLerMem      = ler_q;
  assign Pronto0        = pronto0_q;
  assign Pronto1        = pronto1_q;
  assign DadoLido0      = lido0_q;
  assign DadoLido1      = lido1_q;

`ifdef ARBITRO_CONTADORES_EN
  logic [15:0] cont0_q, cont0_d;
  logic [15:0] cont1_q, cont1_d;

  // Count on the edge that raises Pronto; an access aborted by reset never
  // gets there, so it is never counted. Natural 16-bit wrap.
  always_comb begin
    cont0_d = cont0_q + {15'd0, pronto0_d};
    cont1_d = cont1_q + {15'd0, pronto1_d};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cont0_q <= 16'd0;
      cont1_q <= 16'd0;
    end else begin
      cont0_q <= cont0_d;
      cont1_q <= cont1_d;
    end
  end

  assign ContAcessos0 = cont0_q;
  assign ContAcessos1 = cont1_q;
`endif

  // The single-port memory must never be asked to read and write at once.
  a_strobe_exclusivo: assert property (@(posedge Clock) disable iff (Reset)
    !(MemEscMem && MemLerMem));

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Purpose : directed self-checking bench for arbitro_memoria_dados with a
//           behavioural single-port memory (write rising edge, read falling edge).
// Latency/backpressure: requesters hold Req until their Pronto pulse.
module tb_arbitro_memoria_dados;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Req0 = 1'b0, Esc0 = 1'b0;
  logic [7:0] End0 = 8'd0, Dado0 = 8'd0;
  logic       Req1 = 1'b0, Esc1 = 1'b0;
  logic [7:0] End1 = 8'd0, Dado1 = 8'd0;
  logic       Pronto0, Pronto1;
  logic [7:0] DadoLido0, DadoLido1;
  logic [7:0] MemEndereco, MemDadoEscrito;
  logic       MemEscMem, MemLerMem;
  logic [7:0] MemDadoLido = 8'd0;
`ifdef ARBITRO_CONTADORES_EN
  logic [15:0] ContAcessos0, ContAcessos1;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int viol = 0;

  always #5 Clock = ~Clock;

  arbitro_memoria_dados #(.LARGURA_END(8), .LARGURA_DADO(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Esc0(Esc0), .End0(End0), .Dado0(Dado0),
    .Pronto0(Pronto0), .DadoLido0(DadoLido0),
    .Req1(Req1), .Esc1(Esc1), .End1(End1), .Dado1(Dado1),
    .Pronto1(Pronto1), .DadoLido1(DadoLido1),
    .MemEndereco(MemEndereco), .MemDadoEscrito(MemDadoEscrito),
    .MemEscMem(MemEscMem), .MemLerMem(MemLerMem), .MemDadoLido(MemDadoLido)
`ifdef ARBITRO_CONTADORES_EN
    , .ContAcessos0(ContAcessos0), .ContAcessos1(ContAcessos1)
`endif
  );

  // Behavioural memory; pre_* lets the bench preload it while the DUT is in reset.
  logic [7:0] mem [0:255];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'd0, pre_dat = 8'd0;

  always @(posedge Clock) begin
    if (MemEscMem) mem[MemEndereco] <= MemDadoEscrito;
    if (pre_we)    mem[pre_addr]    <= pre_dat;
  end

  always @(negedge Clock) begin
    if (MemLerMem) MemDadoLido <= mem[MemEndereco];
    if (MemEscMem && MemLerMem) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One complete access: raises Req, waits (bounded) for Pronto, drops Req and
  // steps past RESPOSTA. lat = ticks from request to Pronto (-1 on timeout),
  // nstrb = cycles with the expected strobe/address/data on the memory port.
  task automatic acesso(input int p, input logic esc, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] lido,
                        output int lat, output int nstrb);
    logic pr;
    if (p == 0) begin Req0 = 1'b1; Esc0 = esc; End0 = a; Dado0 = d; end
    else        begin Req1 = 1'b1; Esc1 = esc; End1 = a; Dado1 = d; end
    lat = -1; nstrb = 0; lido = 8'd0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if ((esc ? MemEscMem : MemLerMem) && MemEndereco == a &&
          (!esc || MemDadoEscrito == d))
        nstrb++;
      pr = (p == 0) ? Pronto0 : Pronto1;
      if (pr) begin
        lat  = i;
        lido = (p == 0) ? DadoLido0 : DadoLido1;
        break;
      end
    end
    if (p == 0) Req0 = 1'b0; else Req1 = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] padrao(input int i);
    if (i == 8) return 8'h2A;
    if (i == 3) return 8'h11;
    return 8'(i) ^ 8'hA0;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] lido;
    int lat, nstrb;
    int ev_port [4];
    int ev_tick [4];
    int nev;

    // Preload memory while the DUT is held in reset.
    for (int i = 0; i < 256; i++) begin
      pre_we = 1'b1; pre_addr = 8'(i); pre_dat = padrao(i);
      tick();
    end
    pre_we = 1'b0;

    check("rst_pronto0", Pronto0, 0);
    check("rst_pronto1", Pronto1, 0);
    check("rst_escmem", MemEscMem, 0);
    check("rst_lermem", MemLerMem, 0);
    check("rst_end", MemEndereco, 0);
    check("rst_dadoesc", MemDadoEscrito, 0);
    check("rst_lido0", DadoLido0, 0);
    check("rst_lido1", DadoLido1, 0);
    Reset = 1'b0;
    tick();

    // 1: port 0 read of address 8.
    Req0 = 1'b1; Esc0 = 1'b0; End0 = 8'd8;
    tick();
    check("t1_ler", MemLerMem, 1);
    check("t1_esc", MemEscMem, 0);
    check("t1_end", MemEndereco, 8);
    check("t1_pronto_early", Pronto0, 0);
    tick();
    check("t1_pronto0", Pronto0, 1);
    check("t1_lido0", DadoLido0, 8'h2A);
    check("t1_ler_off", MemLerMem, 0);
    check("t1_pronto1", Pronto1, 0);
    Req0 = 1'b0;
    tick();
    check("t1_pronto0_off", Pronto0, 0);

    // 2: port 1 write then port 0 read-back.
    acesso(1, 1'b1, 8'd8, 8'h0F, lido, lat, nstrb);
    check("t2_lat", lat, 2);
    check("t2_nstrb", nstrb, 1);
    check("t2_lido1", lido, 8'h00);
    check("t2_lido0_kept", DadoLido0, 8'h2A);
    acesso(0, 1'b0, 8'd8, 8'h00, lido, lat, nstrb);
    check("t2_rd_lat", lat, 2);
    check("t2_rd_data", lido, 8'h0F);
    check("t2_lido1_kept", DadoLido1, 8'h00);

    // 3: simultaneous continuous requests right after reset alternate 0,1,0,1.
    Reset = 1'b1; tick(); Reset = 1'b0;
    Req0 = 1'b1; Esc0 = 1'b0; End0 = 8'd0;
    Req1 = 1'b1; Esc1 = 1'b0; End1 = 8'd1;
    nev = 0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (Pronto0 && nev < 4) begin ev_port[nev] = 0; ev_tick[nev] = t; nev++; end
      if (Pronto1 && nev < 4) begin ev_port[nev] = 1; ev_tick[nev] = t; nev++; end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    tick(); tick();
    check("t3_nev", nev, 4);
    for (int k = 0; k < nev; k++) begin
      check($sformatf("t3_port%0d", k), ev_port[k], k % 2);
      check($sformatf("t3_tick%0d", k), ev_tick[k], 2 + 3 * k);
    end
    check("t3_lido0", DadoLido0, 8'hA0);
    check("t3_lido1", DadoLido1, 8'hA1);

    // 4: reset in the middle of a write cycle aborts it.
    Req0 = 1'b1; Esc0 = 1'b1; End0 = 8'd3; Dado0 = 8'hFF;
    tick();
    check("t4_esc_on", MemEscMem, 1);
    check("t4_end", MemEndereco, 3);
    #2 Reset = 1'b1;
    #1;
    check("t4_esc_drop", MemEscMem, 0);
    tick();
    check("t4_no_pronto", Pronto0, 0);
    Req0 = 1'b0; Esc0 = 1'b0;
    Reset = 1'b0;
    tick();
    check("t4_no_pronto2", Pronto0, 0);
    acesso(0, 1'b0, 8'd3, 8'h00, lido, lat, nstrb);
    check("t4_rd_lat", lat, 2);
    check("t4_rd_data", lido, 8'h11);

    // 5: continuous port 0 reads, End0 disturbed during ACESSO.
    Req0 = 1'b1; Esc0 = 1'b0; End0 = 8'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t5_ler%0d", k), MemLerMem, 1);
      check($sformatf("t5_end%0d", k), MemEndereco, k);
      End0 = 8'h55;
      #2;
      check($sformatf("t5_latch%0d", k), MemEndereco, k);
      tick();
      check($sformatf("t5_pronto%0d", k), Pronto0, 1);
      check($sformatf("t5_dado%0d", k), DadoLido0, 8'hA0 + 8'(k));
      End0 = 8'(k + 1);
      if (k == 2) Req0 = 1'b0;
      tick();
      check($sformatf("t5_idle%0d", k), Pronto0, 0);
    end
    tick();

    // Full-range address passes unchanged.
    acesso(1, 1'b1, 8'hFF, 8'h5A, lido, lat, nstrb);
    check("tff_wr_strb", nstrb, 1);
    acesso(0, 1'b0, 8'hFF, 8'h00, lido, lat, nstrb);
    check("tff_rd_strb", nstrb, 1);
    check("tff_rd_data", lido, 8'h5A);

`ifdef ARBITRO_CONTADORES_EN
    // 6: access counters.
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("t6_rst0", ContAcessos0, 0);
    check("t6_rst1", ContAcessos1, 0);
    for (int k = 0; k < 5; k++) acesso(0, 1'b0, 8'(k), 8'h00, lido, lat, nstrb);
    for (int k = 0; k < 3; k++) acesso(1, 1'b1, 8'(16 + k), 8'(k), lido, lat, nstrb);
    check("t6_cont0", ContAcessos0, 5);
    check("t6_cont1", ContAcessos1, 3);
    Reset = 1'b1; #1;
    check("t6_clr0", ContAcessos0, 0);
    check("t6_clr1", ContAcessos1, 0);
    tick(); Reset = 1'b0;
`endif

    check("strobe_exclusive", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
